// File: rtl/fir_decimate_round.sv
// Decimating output stage for a FIR: keeps one accumulator sample in every
// dec, then rounds (half-to-even), saturates to OW bits and flags clipping.
module fir_decimate_round #(
    parameter int IW          = 32,
    parameter int OW          = 16,
    parameter int SHIFT       = 8,
    parameter int DECW        = 8,
    parameter int DEFAULT_DEC = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce,
    input  logic [IW-1:0]   i_acc,
    input  logic            i_dec_wr,
    input  logic [DECW-1:0] i_dec,
    input  logic            i_clr_ovfl,
    output logic            o_ce,
    output logic [OW-1:0]   o_sample,
    output logic            o_ovfl
);

    localparam int STAGES = 3;
    // One extra MSB so a round-up carry out of the kept field survives
    localparam int RW = IW - SHIFT + 1;
    localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
    localparam logic [OW-1:0] SMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};

    logic [DECW-1:0]   r_dec;
    logic [DECW-1:0]   r_phase;
    logic [STAGES:1]   r_vld_pipe;
    logic [IW-1:0]     r_cap;
    logic [RW-1:0]     r_rnd;

    logic [DECW-1:0]   w_dec_eff;
    logic              w_phase_last;
    logic              w_keep;
    logic [RW-1:0]     w_trunc;
    logic [SHIFT-1:0]  w_frac;
    logic              w_round_up;
    logic [RW-1:0]     w_rnd;
    logic [RW-2:OW-1]  w_hi;
    logic              w_pos_clip;
    logic              w_neg_clip;
    logic [OW-1:0]     w_sat;

    assign w_dec_eff    = (r_dec == '0) ? DECW'(1) : r_dec;
    assign w_phase_last = (r_phase >= w_dec_eff - DECW'(1));
    // A ratio write resyncs the phase, so a same-cycle sample is dropped
    assign w_keep       = i_ce && !i_dec_wr && (r_phase == '0);

    assign w_trunc    = {r_cap[IW-1], r_cap[IW-1:SHIFT]};
    assign w_frac     = r_cap[SHIFT-1:0];
    assign w_round_up = (w_frac > HALF) || ((w_frac == HALF) && r_cap[SHIFT]);
    assign w_rnd      = w_trunc + {{(RW-1){1'b0}}, w_round_up};

    // In range only if every bit above the OW-bit sign matches the true sign
    assign w_hi       = r_rnd[RW-2:OW-1];
    assign w_pos_clip = !r_rnd[RW-1] && (|w_hi);
    assign w_neg_clip =  r_rnd[RW-1] && !(&w_hi);
    assign w_sat      = w_pos_clip ? SMAX : (w_neg_clip ? SMIN : r_rnd[OW-1:0]);

    assign o_ce = r_vld_pipe[STAGES];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dec   <= DECW'(DEFAULT_DEC);
            r_phase <= '0;
        end else if (i_dec_wr) begin
            r_dec   <= i_dec;
            r_phase <= '0;
        end else if (i_ce) begin
            r_phase <= w_phase_last ? '0 : r_phase + DECW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld_pipe <= '0;
            r_cap      <= '0;
            r_rnd      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_keep};
            if (w_keep)
                r_cap <= i_acc;
            if (r_vld_pipe[1])
                r_rnd <= w_rnd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_sample <= '0;
            o_ovfl   <= 1'b0;
        end else begin
            if (r_vld_pipe[2])
                o_sample <= w_sat;
            // Set has priority over clear
            if (r_vld_pipe[2] && (w_pos_clip || w_neg_clip))
                o_ovfl <= 1'b1;
            else if (i_clr_ovfl)
                o_ovfl <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_decimate_round.sv
// Bench for fir_decimate_round: arithmetic reference model checked every
// cycle, plus directed vectors with literal expected outputs.
module tb_fir_decimate_round;

    localparam int IW = 32, OW = 16, SHIFT = 8, DECW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ce = 1'b0;
    logic [IW-1:0]   acc = '0;
    logic            dec_wr = 1'b0;
    logic [DECW-1:0] dec = '0;
    logic            clr = 1'b0;
    logic            o_ce;
    logic [OW-1:0]   o_sample;
    logic            o_ovfl;

    fir_decimate_round #(.IW(IW), .OW(OW), .SHIFT(SHIFT), .DECW(DECW), .DEFAULT_DEC(1)) dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_acc(acc), .i_dec_wr(dec_wr),
        .i_dec(dec), .i_clr_ovfl(clr), .o_ce(o_ce), .o_sample(o_sample), .o_ovfl(o_ovfl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [OW-1:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: exact integer rounding of acc/2^SHIFT, half to even, then clamp
    function automatic logic [OW-1:0] ref_out(input logic [IW-1:0] a, output bit sat);
        longint v, q, r;
        v = longint'(signed'(a));
        q = v >>> SHIFT;
        r = v - q * (longint'(1) << SHIFT);
        if (2 * r > (longint'(1) << SHIFT) || (2 * r == (longint'(1) << SHIFT) && (q & 1) != 0))
            q = q + 1;
        sat = 1'b0;
        if (q > 32767) begin q = 32767; sat = 1'b1; end
        else if (q < -32768) begin q = -32768; sat = 1'b1; end
        return q[OW-1:0];
    endfunction

    // Model state: decimation bookkeeping plus a 3-cycle delay line
    int            m_dec = 1, m_phase = 0;
    bit            m_v1, m_v2, m_s1, m_s2;
    logic [OW-1:0] m_d1, m_d2;
    bit            m_ce = 1'b0, m_ovfl = 1'b0;
    logic [OW-1:0] m_sample = '0;

    always @(posedge clk) begin
        bit keep, s;
        logic [OW-1:0] d;
        if (rst) begin
            m_dec = 1; m_phase = 0;
            m_v1 = 0; m_v2 = 0; m_ce = 0; m_ovfl = 0; m_sample = '0;
        end else begin
            m_ce = m_v2;
            if (m_v2) m_sample = m_d2;
            if (m_v2 && m_s2) m_ovfl = 1'b1;
            else if (clr) m_ovfl = 1'b0;
            m_v2 = m_v1; m_d2 = m_d1; m_s2 = m_s1;
            keep = 1'b0;
            if (dec_wr) begin
                m_dec = (dec == 0) ? 1 : int'(dec);
                m_phase = 0;
            end else if (ce) begin
                keep = (m_phase == 0);
                m_phase = (m_phase + 1) % m_dec;
            end
            d = ref_out(acc, s);
            m_v1 = keep; m_d1 = d; m_s1 = s;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_ce", {31'b0, o_ce}, {31'b0, m_ce});
            chk("o_sample", {16'b0, o_sample}, {16'b0, m_sample});
            chk("o_ovfl", {31'b0, o_ovfl}, {31'b0, m_ovfl});
            if (o_ce) got.push_back(o_sample);
        end
    end

    task automatic drive(input bit c, input logic [IW-1:0] a, input bit w = 0,
                         input logic [DECW-1:0] dv = 0, input bit cl = 0);
        @(negedge clk);
        ce = c; acc = a; dec_wr = w; dec = dv; clr = cl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0);
    endtask

    task automatic check_got(input string name, input logic [OW-1:0] exp[$]);
        @(posedge clk); #1;
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", name, i), {16'b0, got[i]}, {16'b0, exp[i]});
        got.delete();
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 32'h100, 1, 8'd5, 1);
        drive(1, 32'h100, 1, 8'd5, 1);
        chk_en = 1'b1;
        chk("reset_o_ce", {31'b0, o_ce}, 0);
        chk("reset_o_sample", {16'b0, o_sample}, 0);
        chk("reset_o_ovfl", {31'b0, o_ovfl}, 0);
        drive(0, '0);
        rst = 1'b0;
        got.delete();

        // Rounding, half-to-even cases
        drive(1, 32'h00000180); drive(1, 32'h00000280);
        drive(1, 32'h00000281); drive(1, 32'hFFFFFE80);
        idle(5);
        check_got("round", '{16'h0002, 16'h0002, 16'h0003, 16'hFFFE});
        chk("round_ovfl", {31'b0, o_ovfl}, 0);

        // Saturation and sticky flag, then clear
        drive(1, 32'h7FFFFFFF); drive(1, 32'h80000000); drive(1, 32'h007FFF80);
        idle(5);
        check_got("sat", '{16'h7FFF, 16'h8000, 16'h7FFF});
        chk("sat_ovfl", {31'b0, o_ovfl}, 1);
        drive(0, '0, 0, 0, 1);
        drive(0, '0);
        chk("clr_ovfl", {31'b0, o_ovfl}, 0);

        // Decimate by 4
        drive(0, '0, 1, 8'd4);
        for (int n = 0; n < 8; n++) drive(1, 32'(n * 256));
        idle(5);
        check_got("dec4", '{16'h0000, 16'h0004});

        // Ratio 0 behaves as 1
        drive(0, '0, 1, 8'd0);
        drive(1, 32'h100); drive(1, 32'h200); drive(1, 32'h300);
        idle(5);
        check_got("dec0", '{16'h0001, 16'h0002, 16'h0003});

        // Ratio write collides with a sample: that sample is dropped
        drive(1, 32'h100, 1, 8'd3);
        drive(1, 32'h200);
        idle(5);
        check_got("decwr", '{16'h0002});

        // Reset mid-flight, with ovfl previously set
        drive(0, '0, 1, 8'd1);
        drive(1, 32'h7FFFFFFF);
        idle(5);
        check_got("pre_rst", '{16'h7FFF});
        chk("pre_rst_ovfl", {31'b0, o_ovfl}, 1);
        drive(0, '0, 1, 8'd3);
        drive(1, 32'h500);
        drive(1, 32'h900);
        rst = 1'b1;
        drive(1, 32'h900, 1, 8'd7, 0);
        drive(0, '0);
        chk("rst_o_sample", {16'b0, o_sample}, 0);
        chk("rst_o_ovfl", {31'b0, o_ovfl}, 0);
        rst = 1'b0;
        idle(3);
        check_got("rst_drop", '{});
        drive(1, 32'h300); drive(1, 32'h400);
        idle(5);
        check_got("post_rst", '{16'h0003, 16'h0004});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decimate_round.md
FIR_DECIMATE_ROUND -- requirements
Module: fir_decimate_round

Interface
REQ-001 The module SHALL have parameter IW, default 32, meaning the width of the accumulator input from the last FIR tap.
REQ-002 The module SHALL have parameter OW, default 16, meaning the output sample width.
REQ-003 The module SHALL have parameter SHIFT, default 8, meaning the number of accumulator LSBs discarded by rounding; the design requires IW-SHIFT >= OW and SHIFT >= 1.
REQ-004 The module SHALL have parameter DECW, default 8, meaning the width of the decimation-ratio register.
REQ-005 The module SHALL have parameter DEFAULT_DEC, default 1, meaning the decimation ratio loaded at reset.
REQ-006 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The module SHALL have port i_ce, input, 1 bit: a new accumulator sample is valid on i_acc this cycle.
REQ-009 The module SHALL have port i_acc, input, IW bits: signed two's-complement filter accumulator.
REQ-010 The module SHALL have port i_dec_wr, input, 1 bit: load i_dec into the decimation-ratio register.
REQ-011 The module SHALL have port i_dec, input, DECW bits: unsigned decimation ratio; a value of 0 is treated as 1.
REQ-012 The module SHALL have port i_clr_ovfl, input, 1 bit: clear the sticky overflow flag.
REQ-013 The module SHALL have port o_ce, output, 1 bit: a single-cycle strobe marking o_sample valid.
REQ-014 The module SHALL have port o_sample, output, OW bits: signed rounded, saturated, decimated sample.
REQ-015 The module SHALL have port o_ovfl, output, 1 bit: sticky flag, set when any output was saturated.

Function
REQ-016 The module SHALL keep a phase counter over accepted samples that counts 0..dec-1 and wraps to 0, where dec = max(ratio register, 1).
REQ-017 The module SHALL advance the counter on each i_ce cycle, and only the sample accepted when the counter equals 0 SHALL enter the pipeline; all other samples are discarded.
REQ-018 When i_dec_wr is high, the module SHALL load the ratio register and force the counter to 0, and any i_ce sample in the same cycle SHALL be discarded, so the next i_ce sample is kept.
REQ-019 The pipeline SHALL have three register stages (capture, round, saturate), each carrying a valid bit.
REQ-020 The pipeline SHALL advance every clock independently of i_ce, and a sample kept in cycle k SHALL produce o_ce=1 in cycle k+3 for exactly one cycle.
REQ-021 Rounding SHALL be convergent (round half to even) on the SHIFT discarded LSBs.
REQ-022 The rounded result SHALL be computed at IW-SHIFT+1 bits so that a carry on rounding up is never lost.
REQ-023 Saturation SHALL clamp the rounded value to [-2^(OW-1), 2^(OW-1)-1], with positive results clamped to 0x7FFF… and negative results clamped to 0x8000….
REQ-024 o_ovfl SHALL be set in the same cycle as the o_ce of any clamped output, and held until i_clr_ovfl or reset.
REQ-025 If i_clr_ovfl and a new saturation occur in the same cycle, the set SHALL win and o_ovfl SHALL remain 1.
REQ-026 o_sample SHALL hold its last value while o_ce is 0.
REQ-027 Kept samples arriving on consecutive clocks (DEC=1, i_ce continuously high) SHALL each produce one output; throughput is one sample per clock with no back-pressure.

Reset
REQ-028 On i_reset, the module SHALL set the counter to 0 and the ratio register to DEFAULT_DEC, and clear all pipeline valid bits, o_ce, o_sample and o_ovfl to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight samples with no o_ce issued for them, and the first i_ce after reset release SHALL be kept.
REQ-030 While i_reset is high, i_ce, i_dec_wr and i_clr_ovfl SHALL be ignored.

Verification (IW=32, OW=16, SHIFT=8, DEC=1 unless noted)
REQ-031 The bench SHALL drive i_acc = 0x00000180, 0x00000280, 0x00000281, 0xFFFFFE80 on successive i_ce cycles -> o_sample = 0x0002, 0x0002, 0x0003, 0xFFFE, each 3 cycles after its input, with o_ovfl=0.
REQ-032 The bench SHALL drive i_acc = 0x7FFFFFFF, then 0x80000000, then 0x007FFF80 -> o_sample = 0x7FFF, 0x8000, 0x7FFF and o_ovfl=1; then i_clr_ovfl -> o_ovfl=0 on the next cycle.
REQ-033 The bench SHALL write i_dec=4 and then send 8 i_ce samples of n*256 for n=0..7 -> exactly two o_ce pulses, o_sample = 0x0000 and 0x0004.
REQ-034 The bench SHALL write i_dec=0 and then send 3 samples -> 3 outputs (ratio treated as 1).
REQ-035 The bench SHALL assert i_dec_wr (i_dec=3) in the same cycle as an i_ce of 0x100 -> that sample is dropped, and the next sample, 0x200, is output as 0x0002.
REQ-036 The bench SHALL assert i_reset one cycle after a kept sample -> no o_ce follows, all outputs are 0, and the first post-reset sample is output after 3 cycles.
